// File: rtl/alu_pool.sv
// alu_pool: single-cycle integer ALU feeding an in-order result FIFO
// that drains onto the shared IQ write port.
module alu_pool #(
  parameter int XLEN      = 32,
  parameter int IQ_ADDR_W = 5,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear_flag_in,
  input  logic                 rs_calc_enable_in,
  input  logic [3:0]           rs_calc_code_in,
  input  logic [XLEN-1:0]      rs_lhs_in,
  input  logic [XLEN-1:0]      rs_rhs_in,
  input  logic [IQ_ADDR_W-1:0] rs_pos_in_iq_in,
  output logic                 rs_full_out,
  output logic                 iq_write_enable_out,
  input  logic                 iq_grant_in,
  output logic [IQ_ADDR_W-1:0] iq_write_idx_out,
  output logic [XLEN-1:0]      iq_write_result_out,
  output logic                 iq_write_need_cdb_out
);

  localparam int SW = $clog2(XLEN);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IQ_ADDR_W-1:0] idx_q [DEPTH];
  logic [XLEN-1:0]      res_q [DEPTH];
  logic                 cdb_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] alu_res;
  logic            alu_cdb;
  logic [SW-1:0]   sh;
  logic            push, pop;

  assign sh      = rs_rhs_in[SW-1:0];
  assign alu_cdb = rs_calc_code_in < 4'd10;

  // Combinational ALU on the RS operands
  always_comb begin
    alu_res = '0;
    case (rs_calc_code_in)
      4'd0:  alu_res = rs_lhs_in + rs_rhs_in;
      4'd1:  alu_res = rs_lhs_in - rs_rhs_in;
      4'd2:  alu_res = rs_lhs_in << sh;
      4'd3:  alu_res = XLEN'($signed(rs_lhs_in) < $signed(rs_rhs_in));
      4'd4:  alu_res = XLEN'(rs_lhs_in < rs_rhs_in);
      4'd5:  alu_res = rs_lhs_in ^ rs_rhs_in;
      4'd6:  alu_res = rs_lhs_in >> sh;
      4'd7:  alu_res = $unsigned($signed(rs_lhs_in) >>> sh);
      4'd8:  alu_res = rs_lhs_in | rs_rhs_in;
      4'd9:  alu_res = rs_lhs_in & rs_rhs_in;
      4'd10: alu_res = XLEN'(rs_lhs_in == rs_rhs_in);
      4'd11: alu_res = XLEN'(rs_lhs_in != rs_rhs_in);
      4'd12: alu_res = XLEN'($signed(rs_lhs_in) < $signed(rs_rhs_in));
      4'd13: alu_res = XLEN'($signed(rs_lhs_in) >= $signed(rs_rhs_in));
      4'd14: alu_res = XLEN'(rs_lhs_in < rs_rhs_in);
      4'd15: alu_res = XLEN'(rs_lhs_in >= rs_rhs_in);
      default: alu_res = '0;
    endcase
  end

  assign rs_full_out = (cnt_q == CW'(DEPTH)) | ~rdy;
  assign iq_write_enable_out = (cnt_q != '0) & rdy & ~clear_flag_in;

  assign push = rdy & ~clear_flag_in & rs_calc_enable_in & ~rs_full_out;
  assign pop  = iq_write_enable_out & iq_grant_in;

  assign iq_write_idx_out      = idx_q[head_q];
  assign iq_write_result_out   = res_q[head_q];
  assign iq_write_need_cdb_out = cdb_q[head_q];

  // Pointer and occupancy next state; flush wins over everything
  always_comb begin
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (clear_flag_in) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  // FIFO state and storage update
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= '0;
        res_q[i] <= '0;
        cdb_q[i] <= 1'b0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (push) begin
        idx_q[tail_q] <= rs_pos_in_iq_in;
        res_q[tail_q] <= alu_res;
        cdb_q[tail_q] <= alu_cdb;
      end
    end
  end

endmodule
